// File: rtl/banked_mem_responder_if.sv
// Request/response bus of the banked memory responder.
interface banked_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic [3:0]  busy;
  logic        stall;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, busy, stall, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, busy, stall, err
  );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank 16-bit word memory with per-bank occupancy counters,
// combinational stall/err request qualification and a two-stage read pipe.
module banked_mem_responder #(
  parameter int unsigned MEM_AW   = 15,
  parameter int unsigned BUSY_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  banked_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned CW    = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BUSY_CYC - 1);

  logic [15:0]       r_mem [DEPTH];
  logic [CW-1:0]     r_cnt [4];
  logic              r_v1;
  logic              r_v2;
  logic [15:0]       r_d1;
  logic [15:0]       r_d2;

  logic              w_present;
  logic              w_err;
  logic              w_stall;
  logic              w_accept;
  logic [1:0]        w_bank;
  logic [3:0]        w_busy;
  logic [MEM_AW-1:0] w_word;

  // Request qualification: legality, bank conflict and acceptance.
  always_comb begin
    w_bank    = bus.addr[2:1];
    w_word    = bus.addr[MEM_AW:1];
    for (int unsigned b = 0; b < 4; b++) begin
      w_busy[b] = (r_cnt[b] != '0);
    end
    w_present = (bus.rd | bus.wr) & ~rst;
    w_err     = w_present & ((bus.rd & bus.wr) | bus.addr[0]);
    w_stall   = w_present & ~w_err & w_busy[w_bank];
    w_accept  = w_present & ~w_err & ~w_busy[w_bank];
  end

  assign bus.err      = w_err;
  assign bus.stall    = w_stall;
  assign bus.busy     = w_busy;
  assign bus.data_out = r_v2 ? r_d2 : '0;

  // Per-bank occupancy counters: load on accept, count down to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_accept && (w_bank == 2'(b))) begin
          r_cnt[b] <= LOAD;
        end else if (r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - 1'b1;
        end
      end
    end
  end

  // Array write and read pipe; read data is captured at acceptance so a
  // later write to the same word cannot disturb a read already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[MEM_AW-1:0]] <= '0;
      end
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      if (w_accept && bus.wr) begin
        r_mem[w_word] <= bus.data_in;
      end
      r_v1 <= w_accept & bus.rd;
      r_d1 <= (w_accept & bus.rd) ? r_mem[w_word] : '0;
      r_v2 <= r_v1;
      r_d2 <= r_v1 ? r_d1 : '0;
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed self-checking bench for banked_mem_responder.
module tb_banked_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  banked_mem_responder_if bus ();

  banked_mem_responder #(
    .MEM_AW   (8),
    .BUSY_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with a write presented: must be ignored, outputs quiet.
    rst = 1'b1;
    apply(1'b0, 1'b1, 16'h0008, 16'hFFFF);
    chk("rst_err", {15'b0, bus.err}, 16'h0000);
    chk("rst_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    chk("rst_busy", {12'b0, bus.busy}, 16'h0000);
    chk("rst_dout", bus.data_out, 16'h0000);
    tick();
    rst = 1'b0;

    // Write BEEF to bank 3 in first cycle after reset, then read back.
    apply(1'b0, 1'b1, 16'h0006, 16'hBEEF);
    chk("w3_stall", {15'b0, bus.stall}, 16'h0000);
    chk("w3_err", {15'b0, bus.err}, 16'h0000);
    chk("w3_busy0", {12'b0, bus.busy}, 16'h0000);
    tick();
    for (int i = 1; i <= 3; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("w3_busy_hold", {12'b0, bus.busy}, 16'h0008);
      tick();
    end
    apply(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("w3_busy_clear", {12'b0, bus.busy}, 16'h0000);
    chk("r3_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    apply(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("r3_dout_n5", bus.data_out, 16'h0000);
    tick();
    chk("r3_dout_n6", bus.data_out, 16'hBEEF);
    tick();
    chk("r3_dout_n7", bus.data_out, 16'h0000);

    // Preload 1..4 into one word of each bank on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 16'h0010 + 16'(2 * i), 16'(i + 1));
      chk("pre_stall", {15'b0, bus.stall}, 16'h0000);
      tick();
    end
    idle(4);

    // Back-to-back reads across all banks.
    for (int i = 0; i <= 6; i++) begin
      if (i < 4) apply(1'b1, 1'b0, 16'h0010 + 16'(2 * i), 16'h0000);
      else       apply(1'b0, 1'b0, 16'h0000, 16'h0000);
      if (i < 4) chk("b2b_stall", {15'b0, bus.stall}, 16'h0000);
      chk("b2b_dout", bus.data_out, (i >= 2 && i <= 5) ? 16'(i - 1) : 16'h0000);
      if (i == 3) chk("b2b_busy_n3", {12'b0, bus.busy}, 16'h0007);
      if (i == 4) chk("b2b_busy_n4", {12'b0, bus.busy}, 16'h000E);
      tick();
    end

    // Same-bank conflict: second read stalls three cycles.
    apply(1'b0, 1'b1, 16'h0008, 16'h5A5A);
    tick();
    idle(4);
    apply(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("cf_first_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    for (int k = 1; k <= 3; k++) begin
      apply(1'b1, 1'b0, 16'h0008, 16'h0000);
      chk("cf_stall", {15'b0, bus.stall}, 16'h0001);
      chk("cf_err", {15'b0, bus.err}, 16'h0000);
      if (k == 2) chk("cf_dout_first", bus.data_out, 16'h0000);
      tick();
    end
    apply(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("cf_accept", {15'b0, bus.stall}, 16'h0000);
    tick();
    apply(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("cf_dout_n5", bus.data_out, 16'h0000);
    tick();
    chk("cf_dout_n6", bus.data_out, 16'h5A5A);
    idle(4);

    // Illegal requests: rd&wr, odd address read, odd address write.
    apply(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    chk("il_rw_err", {15'b0, bus.err}, 16'h0001);
    chk("il_rw_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("il_odd_err", {15'b0, bus.err}, 16'h0001);
    chk("il_odd_stall", {15'b0, bus.stall}, 16'h0000);
    chk("il_busy", {12'b0, bus.busy}, 16'h0000);
    tick();
    apply(1'b0, 1'b1, 16'h0001, 16'h7777);
    chk("il_oddw_err", {15'b0, bus.err}, 16'h0001);
    chk("il_dout_a", bus.data_out, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("il_busy_after", {12'b0, bus.busy}, 16'h0000);
    chk("il_dout_b", bus.data_out, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    apply(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("il_nowrite_rw", bus.data_out, 16'h0001);
    tick();
    chk("il_nowrite_odd", bus.data_out, 16'h0000);
    idle(4);

    // Read in flight unaffected by a later write; aliasing above MEM_AW.
    apply(1'b0, 1'b1, 16'h0002, 16'h1234);
    tick();
    idle(3);
    apply(1'b1, 1'b0, 16'h0002, 16'h0000);
    tick();
    apply(1'b0, 1'b1, 16'h0004, 16'h5678);
    chk("wr_after_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    apply(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("pipe_protect", bus.data_out, 16'h1234);
    idle(4);
    apply(1'b1, 1'b0, 16'h1202, 16'h0000);
    chk("alias_err", {15'b0, bus.err}, 16'h0000);
    tick();
    idle(1);
    chk("alias_dout", bus.data_out, 16'h1234);
    idle(4);

    // Reset while a read is in flight.
    apply(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("rf_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    rst = 1'b1;
    apply(1'b0, 1'b1, 16'h0010, 16'h9999);
    chk("rf_rst_err", {15'b0, bus.err}, 16'h0000);
    chk("rf_rst_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    rst = 1'b0;
    apply(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("rf_dout_n2", bus.data_out, 16'h0000);
    chk("rf_busy_n2", {12'b0, bus.busy}, 16'h0000);
    chk("rf_accept_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rf_dout_n3", bus.data_out, 16'h0000);
    chk("rf_busy_n3", {12'b0, bus.busy}, 16'h0008);
    tick();
    apply(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rf_cleared_w3", bus.data_out, 16'h0000);
    tick();
    chk("rf_cleared_w8", bus.data_out, 16'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
